// File: rtl/mips_cpu_regfile_mp_pkg.sv
// Shared MIPS core definitions: the data word type and the load opcodes
// that select a sub-word merge on writeback.
package mips_cpu_pkg;

    typedef logic [31:0] word_t;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LWL = 6'b100010;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWR = 6'b100110;

endpackage

// File: rtl/mips_cpu_regfile_mp_if.sv
// Bundle of read, writeback and load-scoreboard signals of the GPR file.
// The master side is the pipeline (decode, hazard unit, writeback).
interface mips_cpu_regfile_mp_if #(
    parameter int NREAD = 2,
    parameter int AW    = 5
);
    logic [NREAD*AW-1:0] rd_addr;
    logic [NREAD*32-1:0] rd_data;
    logic [NREAD-1:0]    rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [31:0]         wr_data;
    logic [5:0]          wr_opcode;
    logic [1:0]          wr_vaddr;
    logic                ld_issue;
    logic [AW-1:0]       ld_dest;
    logic [AW:0]         ld_pending;
    logic                sb_overlap;
    logic                misalign;
    logic [31:0]         regv0;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_opcode, wr_vaddr, ld_issue, ld_dest,
        input  rd_data, rd_busy, ld_pending, sb_overlap, misalign, regv0
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_opcode, wr_vaddr, ld_issue, ld_dest,
        output rd_data, rd_busy, ld_pending, sb_overlap, misalign, regv0
    );
endinterface

// File: rtl/mips_cpu_regfile_mp_load_merge.sv
// Combinational sub-word load merge: builds the register's new value from
// its old contents and the aligned memory word, and flags misaligned halves.
module mips_cpu_load_merge
    import mips_cpu_pkg::*;
(
    input  word_t       old_i,
    input  word_t       wr_data_i,
    input  logic [5:0]  opcode_i,
    input  logic [1:0]  vaddr_i,
    output word_t       new_o,
    output logic        misalign_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = wr_data_i[{vaddr_i, 3'b000} +: 8];
    assign half_s = wr_data_i[{vaddr_i[1], 4'b0000} +: 16];

    // Select the merge rule from the opcode; unknown opcodes pass the word through.
    always_comb begin
        new_o      = wr_data_i;
        misalign_o = 1'b0;
        case (opcode_i)
            OP_LB:  new_o = {{24{byte_s[7]}}, byte_s};
            OP_LBU: new_o = {24'h000000, byte_s};
            OP_LH: begin
                new_o      = {{16{half_s[15]}}, half_s};
                misalign_o = vaddr_i[0];
            end
            OP_LHU: begin
                new_o      = {16'h0000, half_s};
                misalign_o = vaddr_i[0];
            end
            OP_LWL: begin
                case (vaddr_i)
                    2'd0:    new_o = {wr_data_i[7:0],  old_i[23:0]};
                    2'd1:    new_o = {wr_data_i[15:0], old_i[15:0]};
                    2'd2:    new_o = {wr_data_i[23:0], old_i[7:0]};
                    default: new_o = wr_data_i;
                endcase
            end
            OP_LWR: begin
                case (vaddr_i)
                    2'd0:    new_o = wr_data_i;
                    2'd1:    new_o = {old_i[31:24], wr_data_i[31:8]};
                    2'd2:    new_o = {old_i[31:16], wr_data_i[31:16]};
                    default: new_o = {old_i[31:8],  wr_data_i[31:24]};
                endcase
            end
            default: new_o = wr_data_i;
        endcase
    end

endmodule

// File: rtl/mips_cpu_regfile_mp.sv
// MIPS GPR file: NREAD combinational read ports, one merging write port,
// optional write-to-read bypass and a scoreboard of registers awaiting loads.
module mips_cpu_regfile_mp
    import mips_cpu_pkg::*;
#(
    parameter int NREAD  = 2,
    parameter int DEPTH  = 32,
    parameter int BYPASS = 1,
    parameter int SB_EN  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    mips_cpu_regfile_mp_if.slave    bus
);

    localparam int AW     = $clog2(DEPTH);
    localparam int V0_IDX = (DEPTH > 2) ? 2 : 0;
    localparam logic [DEPTH-1:0] ONE_HOT0 = {{(DEPTH-1){1'b0}}, 1'b1};

    word_t              regs_q [DEPTH];
    logic [DEPTH-1:0]   busy_q, busy_d, clr_mask_s, set_mask_s;
    logic [AW:0]        ld_pending_q, ld_pending_d;
    logic               sb_overlap_q, sb_overlap_d, misalign_q, misalign_d;
    word_t              merged_s;
    logic               merge_misalign_s, wr_clear_s, wr_commit_s, ld_set_s;
    logic [NREAD*32-1:0] rd_data_s;
    logic [NREAD-1:0]   rd_busy_s;

    function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
        logic [AW:0] cnt;
        cnt = {(AW+1){1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            cnt = cnt + {{AW{1'b0}}, v[k]};
        end
        return cnt;
    endfunction

    // One merge unit serves both the array write and the bypass path.
    mips_cpu_load_merge u_merge (
        .old_i      (regs_q[bus.wr_addr]),
        .wr_data_i  (bus.wr_data),
        .opcode_i   (bus.wr_opcode),
        .vaddr_i    (bus.wr_vaddr),
        .new_o      (merged_s),
        .misalign_o (merge_misalign_s)
    );

    assign wr_clear_s  = bus.wr_en & ~merge_misalign_s;
    assign wr_commit_s = wr_clear_s & (bus.wr_addr != {AW{1'b0}});
    assign ld_set_s    = (SB_EN != 0) & bus.ld_issue & (bus.ld_dest != {AW{1'b0}});

    // Scoreboard next state: clear on writeback, then set on issue so a new load wins.
    always_comb begin
        clr_mask_s   = wr_clear_s ? (ONE_HOT0 << bus.wr_addr) : {DEPTH{1'b0}};
        set_mask_s   = ld_set_s ? (ONE_HOT0 << bus.ld_dest) : {DEPTH{1'b0}};
        busy_d       = (SB_EN != 0) ? ((busy_q & ~clr_mask_s) | set_mask_s) : {DEPTH{1'b0}};
        sb_overlap_d = ld_set_s & busy_q[bus.ld_dest];
        misalign_d   = bus.wr_en & merge_misalign_s;
        ld_pending_d = popcount(busy_d);
    end

    // Scoreboard, pending count and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q       <= {DEPTH{1'b0}};
            ld_pending_q <= {(AW+1){1'b0}};
            sb_overlap_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            ld_pending_q <= ld_pending_d;
            sb_overlap_q <= sb_overlap_d;
            misalign_q   <= misalign_d;
        end
    end

    // Register array write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= 32'h0000_0000;
            end
        end else if (wr_commit_s) begin
            regs_q[bus.wr_addr] <= merged_s;
        end
    end

    // Read ports: r0 and reset read as zero; a committing write bypasses and frees the register.
    always_comb begin
        rd_data_s = {(NREAD*32){1'b0}};
        rd_busy_s = {NREAD{1'b0}};
        for (int i = 0; i < NREAD; i++) begin
            if (rst || (bus.rd_addr[i*AW +: AW] == {AW{1'b0}})) begin
                rd_data_s[i*32 +: 32] = 32'h0000_0000;
                rd_busy_s[i]          = 1'b0;
            end else if ((BYPASS != 0) && wr_commit_s && (bus.wr_addr == bus.rd_addr[i*AW +: AW])) begin
                rd_data_s[i*32 +: 32] = merged_s;
                rd_busy_s[i]          = 1'b0;
            end else begin
                rd_data_s[i*32 +: 32] = regs_q[bus.rd_addr[i*AW +: AW]];
                rd_busy_s[i]          = busy_q[bus.rd_addr[i*AW +: AW]];
            end
        end
    end

    assign bus.rd_data    = rd_data_s;
    assign bus.rd_busy    = rd_busy_s;
    assign bus.ld_pending = ld_pending_q;
    assign bus.sb_overlap = sb_overlap_q;
    assign bus.misalign   = misalign_q;
    assign bus.regv0      = (DEPTH > 2) ? regs_q[V0_IDX] : 32'h0000_0000;

endmodule

// File: tb/tb_mips_cpu_regfile_mp.sv
// Scoreboard bench for mips_cpu_regfile_mp: two DUTs (bypass on / off) share
// stimulus; an array-based reference model predicts every output each cycle.
module tb_mips_cpu_regfile_mp;
    import mips_cpu_pkg::*;

    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_cpu_regfile_mp_if #(.NREAD(2), .AW(AW)) if_b ();
    mips_cpu_regfile_mp_if #(.NREAD(2), .AW(AW)) if_n ();

    mips_cpu_regfile_mp #(.NREAD(2), .DEPTH(32), .BYPASS(1), .SB_EN(1)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b));
    mips_cpu_regfile_mp #(.NREAD(2), .DEPTH(32), .BYPASS(0), .SB_EN(1)) dut_n (
        .clk(clk), .rst(rst), .bus(if_n));

    typedef struct {
        int          cyc;
        int          kind;
        int          dut;
        int          port;
        logic [31:0] exp;
    } chk_t;

    chk_t sbq[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    // stimulus mirror
    logic        s_wen, s_li;
    logic [4:0]  s_wa, s_ld;
    logic [31:0] s_wd;
    logic [5:0]  s_op;
    logic [1:0]  s_v;
    logic [4:0]  s_ra [2];

    // reference model state
    word_t       mreg [32];
    logic [31:0] mbusy;
    logic        m_ovl, m_mis;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic word_t ref_merge(word_t old, word_t d, logic [5:0] op, int v);
        longint od, dd, bv, hv, sh;
        od = longint'(old);
        dd = longint'(d);
        bv = (dd >> (8 * v)) & 255;
        hv = (dd >> (16 * (v / 2))) & 65535;
        case (op)
            OP_LB:   return (bv >= 128) ? word_t'(bv - 256) : word_t'(bv);
            OP_LBU:  return word_t'(bv);
            OP_LH:   return (hv >= 32768) ? word_t'(hv - 65536) : word_t'(hv);
            OP_LHU:  return word_t'(hv);
            OP_LWL: begin
                sh = 8 * (3 - v);
                return word_t'((dd << sh) | (od & ((longint'(1) << sh) - 1)));
            end
            OP_LWR: begin
                sh = 8 * v;
                return word_t'((dd >> sh) | (od & ~((longint'(1) << (32 - sh)) - 1)));
            end
            default: return d;
        endcase
    endfunction

    function automatic bit ref_mis(logic [5:0] op, logic [1:0] v);
        return ((op == OP_LH) || (op == OP_LHU)) && ((int'(v) % 2) == 1);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 32; k++) mreg[k] = 32'h0;
        mbusy = 32'h0;
        m_ovl = 1'b0;
        m_mis = 1'b0;
    endtask

    task automatic push(input int kind, input int dut, input int port, input logic [31:0] exp);
        chk_t c;
        c.cyc = cyc; c.kind = kind; c.dut = dut; c.port = port; c.exp = exp;
        sbq.push_back(c);
    endtask

    task automatic push_both(input int kind, input int port, input logic [31:0] exp);
        push(kind, 0, port, exp);
        push(kind, 1, port, exp);
    endtask

    task automatic drive(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [5:0] op, input logic [1:0] v, input logic li,
                         input logic [4:0] ld, input logic [4:0] ra0, input logic [4:0] ra1);
        s_wen = wen; s_wa = wa; s_wd = wd; s_op = op; s_v = v; s_li = li; s_ld = ld;
        s_ra[0] = ra0; s_ra[1] = ra1;
        if_b.wr_en = wen; if_b.wr_addr = wa; if_b.wr_data = wd; if_b.wr_opcode = op;
        if_b.wr_vaddr = v; if_b.ld_issue = li; if_b.ld_dest = ld; if_b.rd_addr = {ra1, ra0};
        if_n.wr_en = wen; if_n.wr_addr = wa; if_n.wr_data = wd; if_n.wr_opcode = op;
        if_n.wr_vaddr = v; if_n.ld_issue = li; if_n.ld_dest = ld; if_n.rd_addr = {ra1, ra0};
    endtask

    task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
        drive(1'b0, 5'd0, 32'h0, 6'h00, 2'd0, 1'b0, 5'd0, ra0, ra1);
    endtask

    task automatic wr(input logic [4:0] wa, input logic [31:0] wd, input logic [5:0] op,
                      input logic [1:0] v);
        drive(1'b1, wa, wd, op, v, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    // Expected outputs for the current inputs and model state.
    task automatic auto_checks();
        bit          commit;
        logic [4:0]  ra;
        commit = s_wen && !ref_mis(s_op, s_v) && (s_wa != 5'd0);
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                ra = s_ra[p];
                if (rst || ra == 5'd0) begin
                    push(0, d, p, 32'h0);
                    push(1, d, p, 32'h0);
                end else if (d == 1 && commit && s_wa == ra) begin
                    push(0, d, p, ref_merge(mreg[ra], s_wd, s_op, int'(s_v)));
                    push(1, d, p, 32'h0);
                end else begin
                    push(0, d, p, mreg[ra]);
                    push(1, d, p, {31'h0, mbusy[ra]});
                end
            end
        end
        push_both(2, 0, 32'($countones(mbusy)));
        push_both(3, 0, {31'h0, m_ovl});
        push_both(4, 0, {31'h0, m_mis});
        push_both(5, 0, mreg[2]);
    endtask

    task automatic model_edge();
        bit mis;
        if (rst) begin
            model_clear();
        end else begin
            mis   = s_wen && ref_mis(s_op, s_v);
            m_mis = mis;
            m_ovl = s_li && (s_ld != 5'd0) && mbusy[s_ld];
            if (s_wen && !mis) begin
                if (s_wa != 5'd0) mreg[s_wa] = ref_merge(mreg[s_wa], s_wd, s_op, int'(s_v));
                mbusy[s_wa] = 1'b0;
            end
            if (s_li && s_ld != 5'd0) mbusy[s_ld] = 1'b1;
        end
    endtask

    task automatic cycle();
        if (rst) model_clear();
        auto_checks();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [31:0] actual(input chk_t c);
        case (c.kind)
            0: return (c.dut == 1) ? if_b.rd_data[c.port*32 +: 32] : if_n.rd_data[c.port*32 +: 32];
            1: return {31'h0, (c.dut == 1) ? if_b.rd_busy[c.port] : if_n.rd_busy[c.port]};
            2: return {26'h0, (c.dut == 1) ? if_b.ld_pending : if_n.ld_pending};
            3: return {31'h0, (c.dut == 1) ? if_b.sb_overlap : if_n.sb_overlap};
            4: return {31'h0, (c.dut == 1) ? if_b.misalign : if_n.misalign};
            default: return (c.dut == 1) ? if_b.regv0 : if_n.regv0;
        endcase
    endfunction

    string knames [6] = '{"rd_data", "rd_busy", "ld_pending", "sb_overlap", "misalign", "regv0"};

    // Monitor: compare every expectation queued for the present cycle.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            chk_t        c;
            logic [31:0] a;
            c = sbq.pop_front();
            a = actual(c);
            n_checks++;
            if (a === c.exp) n_pass++;
            else $display("FAIL %s dut_bypass=%0d port%0d cyc%0d: got %h expected %h",
                          knames[c.kind], c.dut, c.port, c.cyc, a, c.exp);
        end
    end

    logic [5:0] ops [8] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LWL, OP_LWR, 6'h23, 6'h00};

    initial begin
        model_clear();
        idle(5'd0, 5'd0);
        @(posedge clk); #1;
        idle(5'd2, 5'd5);
        cycle(); cycle();
        rst = 1'b0;

        // r0 ignores writes and loads
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 6'h00, 2'd0, 1'b1, 5'd0, 5'd0, 5'd0); cycle();
        idle(5'd0, 5'd0); push_both(0, 0, 32'h0); push_both(2, 0, 32'h0);
        #1;
        n_checks++;
        if (if_b.rd_data[31:0] === 32'h0000_0000) n_pass++;
        else $display("FAIL direct r0 read: got %h expected 00000000", if_b.rd_data[31:0]);
        cycle();

        // byte / half merges into r3
        wr(5'd3, 32'h1122_3344, 6'h00, 2'd0); cycle();
        wr(5'd3, 32'h80FF_7F01, OP_LB, 2'd1); cycle();
        idle(5'd3, 5'd0); push_both(0, 0, 32'h0000_007F);
        #1;
        n_checks++;
        if (if_n.rd_data[31:0] === 32'h0000_007F) n_pass++;
        else $display("FAIL direct lb v=1: got %h expected 0000007f", if_n.rd_data[31:0]);
        cycle();
        wr(5'd3, 32'h80FF_7F01, OP_LB, 2'd3); cycle();
        idle(5'd3, 5'd0); push_both(0, 0, 32'hFFFF_FF80); cycle();
        wr(5'd3, 32'h80FF_7F01, OP_LHU, 2'd2); cycle();
        idle(5'd3, 5'd0); push_both(0, 0, 32'h0000_80FF); cycle();

        // unaligned word merges into r4
        wr(5'd4, 32'hAABB_CCDD, 6'h00, 2'd0); cycle();
        wr(5'd4, 32'h0102_0304, OP_LWL, 2'd1); cycle();
        idle(5'd4, 5'd0); push_both(0, 0, 32'h0304_CCDD); cycle();
        wr(5'd4, 32'hAABB_CCDD, 6'h00, 2'd0); cycle();
        wr(5'd4, 32'h0102_0304, OP_LWR, 2'd2); cycle();
        idle(5'd4, 5'd0); push_both(0, 0, 32'hAABB_0102); cycle();

        // bypass vs no bypass on r7
        wr(5'd7, 32'h1111_1111, 6'h00, 2'd0); cycle();
        drive(1'b1, 5'd7, 32'hCAFE_F00D, 6'h00, 2'd0, 1'b0, 5'd0, 5'd0, 5'd7);
        push(0, 1, 1, 32'hCAFE_F00D); push(0, 0, 1, 32'h1111_1111);
        #1;
        n_checks++;
        if (if_b.rd_data[63:32] === 32'hCAFE_F00D) n_pass++;
        else $display("FAIL direct bypass: got %h expected cafef00d", if_b.rd_data[63:32]);
        n_checks++;
        if (if_n.rd_data[63:32] === 32'h1111_1111) n_pass++;
        else $display("FAIL direct no-bypass: got %h expected 11111111", if_n.rd_data[63:32]);
        cycle();

        // scoreboard overlap, simultaneous issue+writeback, misaligned half on r9
        drive(1'b0, 5'd0, 32'h0, 6'h00, 2'd0, 1'b1, 5'd9, 5'd9, 5'd0); cycle();
        drive(1'b0, 5'd0, 32'h0, 6'h00, 2'd0, 1'b1, 5'd9, 5'd9, 5'd0); cycle();
        idle(5'd9, 5'd0); push_both(3, 0, 32'h1); cycle();
        idle(5'd9, 5'd0); push_both(3, 0, 32'h0); cycle();
        drive(1'b1, 5'd9, 32'h0000_0055, 6'h00, 2'd0, 1'b1, 5'd9, 5'd0, 5'd0); cycle();
        idle(5'd9, 5'd0); push_both(2, 0, 32'h1); push_both(1, 0, 32'h1); cycle();
        wr(5'd9, 32'hDEAD_0000, OP_LH, 2'd1); cycle();
        idle(5'd9, 5'd0); push_both(4, 0, 32'h1); push_both(0, 0, 32'h0000_0055);
        push_both(1, 0, 32'h1); cycle();

        // reset mid-run with r5 written and busy
        wr(5'd5, 32'h0000_1234, 6'h00, 2'd0); cycle();
        drive(1'b0, 5'd0, 32'h0, 6'h00, 2'd0, 1'b1, 5'd5, 5'd5, 5'd0); cycle();
        idle(5'd5, 5'd5); push_both(1, 0, 32'h1); cycle();
        rst = 1'b1; #1;
        idle(5'd5, 5'd5); push_both(0, 0, 32'h0); push_both(1, 0, 32'h0); push_both(2, 0, 32'h0);
        cycle();
        rst = 1'b0;
        idle(5'd5, 5'd5); push_both(0, 0, 32'h0); push_both(1, 0, 32'h0); push_both(2, 0, 32'h0);
        cycle();

        // randomized traffic over a small register window to provoke collisions
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 11)), $urandom,
                  ops[$urandom_range(0, 7)], 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 11)),
                  5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)));
            cycle();
        end

        idle(5'd0, 5'd0);
        @(negedge clk); #1;
        while (sbq.size() > 0) begin
            chk_t c;
            c = sbq.pop_front();
            n_checks++;
            $display("FAIL undrained %s dut_bypass=%0d port%0d: got none expected %h",
                     knames[c.kind], c.dut, c.port, c.exp);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
